// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with make/break/extended tracking,
// shift and caps-lock state, and a first-word fall-through output FIFO.
module ps2_ascii_decoder #(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] UNKNOWN_CHAR = 8'h2A,
  parameter bit         DROP_UNKNOWN = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  output logic [7:0]                    ascii_data,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          shift_active,
  output logic                          caps_lock,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t         state;
  logic           lshift, rshift;
  logic           lshift_next, rshift_next;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           map_hit, is_letter, upper;
  logic [7:0]     map_char, letter, push_char;
  logic           push_req, pop, full, do_push;

  // Make-code translation using the shift/caps state in effect before this byte
  always_comb begin
    map_hit   = 1'b1;
    is_letter = 1'b0;
    letter    = 8'h00;
    map_char  = 8'h00;
    upper     = shift_active ^ caps_lock;
    case (scan_code)
      8'h1C: begin is_letter = 1'b1; letter = "a"; end
      8'h32: begin is_letter = 1'b1; letter = "b"; end
      8'h21: begin is_letter = 1'b1; letter = "c"; end
      8'h23: begin is_letter = 1'b1; letter = "d"; end
      8'h24: begin is_letter = 1'b1; letter = "e"; end
      8'h2B: begin is_letter = 1'b1; letter = "f"; end
      8'h34: begin is_letter = 1'b1; letter = "g"; end
      8'h33: begin is_letter = 1'b1; letter = "h"; end
      8'h43: begin is_letter = 1'b1; letter = "i"; end
      8'h3B: begin is_letter = 1'b1; letter = "j"; end
      8'h42: begin is_letter = 1'b1; letter = "k"; end
      8'h4B: begin is_letter = 1'b1; letter = "l"; end
      8'h3A: begin is_letter = 1'b1; letter = "m"; end
      8'h31: begin is_letter = 1'b1; letter = "n"; end
      8'h44: begin is_letter = 1'b1; letter = "o"; end
      8'h4D: begin is_letter = 1'b1; letter = "p"; end
      8'h15: begin is_letter = 1'b1; letter = "q"; end
      8'h2D: begin is_letter = 1'b1; letter = "r"; end
      8'h1B: begin is_letter = 1'b1; letter = "s"; end
      8'h2C: begin is_letter = 1'b1; letter = "t"; end
      8'h3C: begin is_letter = 1'b1; letter = "u"; end
      8'h2A: begin is_letter = 1'b1; letter = "v"; end
      8'h1D: begin is_letter = 1'b1; letter = "w"; end
      8'h22: begin is_letter = 1'b1; letter = "x"; end
      8'h35: begin is_letter = 1'b1; letter = "y"; end
      8'h1A: begin is_letter = 1'b1; letter = "z"; end
      8'h16: map_char = shift_active ? "!" : "1";
      8'h1E: map_char = shift_active ? "@" : "2";
      8'h26: map_char = shift_active ? "#" : "3";
      8'h25: map_char = shift_active ? "$" : "4";
      8'h2E: map_char = shift_active ? "%" : "5";
      8'h36: map_char = shift_active ? "^" : "6";
      8'h3D: map_char = shift_active ? "&" : "7";
      8'h3E: map_char = shift_active ? "*" : "8";
      8'h46: map_char = shift_active ? "(" : "9";
      8'h45: map_char = shift_active ? ")" : "0";
      8'h0E: map_char = shift_active ? 8'h7E : 8'h60;
      8'h4E: map_char = shift_active ? 8'h5F : 8'h2D;
      8'h55: map_char = shift_active ? 8'h2B : 8'h3D;
      8'h54: map_char = shift_active ? 8'h7B : 8'h5B;
      8'h5B: map_char = shift_active ? 8'h7D : 8'h5D;
      8'h5D: map_char = shift_active ? 8'h7C : 8'h5C;
      8'h4C: map_char = shift_active ? 8'h3A : 8'h3B;
      8'h52: map_char = shift_active ? 8'h22 : 8'h27;
      8'h41: map_char = shift_active ? 8'h3C : 8'h2C;
      8'h49: map_char = shift_active ? 8'h3E : 8'h2E;
      8'h4A: map_char = shift_active ? 8'h3F : 8'h2F;
      8'h29: map_char = 8'h20;
      8'h5A: map_char = 8'h0D;
      8'h66: map_char = 8'h08;
      8'h0D: map_char = 8'h09;
      default: map_hit = 1'b0;
    endcase
    if (is_letter)
      map_char = upper ? (letter - 8'h20) : letter;
  end

  // Per-byte action: shift updates and push request for the current state
  always_comb begin
    push_req    = 1'b0;
    push_char   = 8'h00;
    lshift_next = lshift;
    rshift_next = rshift;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          case (scan_code)
            8'hF0, 8'hE0, 8'h58: ;
            8'h12: lshift_next = 1'b1;
            8'h59: rshift_next = 1'b1;
            default: begin
              if (map_hit) begin
                push_req  = 1'b1;
                push_char = map_char;
              end else if (!DROP_UNKNOWN) begin
                push_req  = 1'b1;
                push_char = UNKNOWN_CHAR;
              end
            end
          endcase
        end
        BRK: begin
          if (scan_code == 8'h12) lshift_next = 1'b0;
          if (scan_code == 8'h59) rshift_next = 1'b0;
        end
        EXT: begin
          if (scan_code == 8'h5A) begin
            push_req  = 1'b1;
            push_char = 8'h0D;
          end else if (scan_code == 8'h4A) begin
            push_req  = 1'b1;
            push_char = 8'h2F;
          end
        end
        default: ;
      endcase
    end
  end

  assign ascii_valid = (fifo_count != '0);
  assign ascii_data  = mem[rd_ptr];
  assign pop         = ascii_valid & ascii_ready;
  assign full        = (fifo_count == CW'(FIFO_DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO can still accept
  assign do_push     = push_req & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lshift       <= 1'b0;
      rshift       <= 1'b0;
      shift_active <= 1'b0;
      caps_lock    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      lshift       <= lshift_next;
      rshift       <= rshift_next;
      shift_active <= lshift_next | rshift_next;
      if (scan_valid) begin
        case (state)
          IDLE: begin
            if (scan_code == 8'hF0)      state <= BRK;
            else if (scan_code == 8'hE0) state <= EXT;
            if (scan_code == 8'h58) caps_lock <= ~caps_lock;
          end
          EXT:     state <= (scan_code == 8'hF0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end
      if (do_push) begin
        mem[wr_ptr] <= push_char;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!do_push && pop) fifo_count <= fifo_count - CW'(1);
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: a depth-4 instance for decode/FIFO
// behaviour and a depth-8 DROP_UNKNOWN instance for discard and async reset.
module tb_ps2_ascii_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       ascii_ready;
  logic       clr_overflow;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic [2:0] a_count;
  logic [3:0] b_count;
  logic       a_shift, b_shift, a_caps, b_caps, a_ovf, b_ovf;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ps2_ascii_decoder #(.FIFO_DEPTH(4), .UNKNOWN_CHAR(8'h2A), .DROP_UNKNOWN(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .ascii_data(a_data), .ascii_valid(a_valid), .ascii_ready(ascii_ready),
    .fifo_count(a_count), .shift_active(a_shift), .caps_lock(a_caps),
    .overflow(a_ovf), .clr_overflow(clr_overflow)
  );

  ps2_ascii_decoder #(.FIFO_DEPTH(8), .UNKNOWN_CHAR(8'h2A), .DROP_UNKNOWN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .ascii_data(b_data), .ascii_valid(b_valid), .ascii_ready(ascii_ready),
    .fifo_count(b_count), .shift_active(b_shift), .caps_lock(b_caps),
    .overflow(b_ovf), .clr_overflow(clr_overflow)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One scan byte strobed for a single cycle; returns on the following negedge
  task automatic apply_stimulus(input logic [7:0] code);
    @(negedge clk);
    scan_code  = code;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] expected);
    check_output({tag, "_valid"}, {31'd0, a_valid}, 32'd1);
    check_output({tag, "_data"}, {24'd0, a_data}, {24'd0, expected});
    ascii_ready = 1'b1;
    @(negedge clk);
    ascii_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; scan_code = 8'h00; scan_valid = 1'b0;
    ascii_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_valid", {31'd0, a_valid}, 32'd0);
    check_output("rst_data", {24'd0, a_data}, 32'h00);
    check_output("rst_count", {29'd0, a_count}, 32'd0);
    check_output("rst_ovf", {31'd0, a_ovf}, 32'd0);
    rst_n = 1'b1;

    // basic make, then pop back to empty
    apply_stimulus(8'h1C);
    check_output("t1_count", {29'd0, a_count}, 32'd1);
    pop_expect("t1_a", 8'h61);
    check_output("t1_empty_count", {29'd0, a_count}, 32'd0);
    check_output("t1_empty_valid", {31'd0, a_valid}, 32'd0);

    // shift make/break
    apply_stimulus(8'h12);
    check_output("t2_shift_on", {31'd0, a_shift}, 32'd1);
    check_output("t2_shift_nopush", {29'd0, a_count}, 32'd0);
    apply_stimulus(8'h1C);
    pop_expect("t2_A", 8'h41);
    apply_stimulus(8'hF0); apply_stimulus(8'h1C);
    check_output("t2_break_nopush", {29'd0, a_count}, 32'd0);
    apply_stimulus(8'hF0); apply_stimulus(8'h12);
    check_output("t2_shift_off", {31'd0, a_shift}, 32'd0);
    apply_stimulus(8'h1C);
    pop_expect("t2_a", 8'h61);

    // caps lock interaction
    apply_stimulus(8'h58);
    check_output("t3_caps", {31'd0, a_caps}, 32'd1);
    apply_stimulus(8'h1C);
    pop_expect("t3_caps_A", 8'h41);
    apply_stimulus(8'h12); apply_stimulus(8'h1C);
    pop_expect("t3_caps_shift_a", 8'h61);
    apply_stimulus(8'h16);
    pop_expect("t3_bang", 8'h21);
    apply_stimulus(8'hF0); apply_stimulus(8'h12);
    apply_stimulus(8'h4E);
    pop_expect("t3_minus", 8'h2D);
    apply_stimulus(8'h58);
    check_output("t3_caps_off", {31'd0, a_caps}, 32'd0);
    apply_stimulus(8'h0D);
    pop_expect("t3_tab", 8'h09);

    // prefixes and unknown code
    apply_stimulus(8'hF0); apply_stimulus(8'h1C);
    check_output("t4_brk_nopush", {29'd0, a_count}, 32'd0);
    apply_stimulus(8'hE0); apply_stimulus(8'h5A);
    pop_expect("t4_kp_enter", 8'h0D);
    apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h5A);
    check_output("t4_extbrk_nopush", {29'd0, a_count}, 32'd0);
    apply_stimulus(8'hE0); apply_stimulus(8'h75);
    check_output("t4_ext_unmapped", {29'd0, a_count}, 32'd0);
    apply_stimulus(8'hE0); apply_stimulus(8'h4A);
    pop_expect("t4_kp_slash", 8'h2F);
    apply_stimulus(8'h05);
    pop_expect("t4_unknown", 8'h2A);

    // fill past depth 4, overflow and recovery
    apply_stimulus(8'h1C); apply_stimulus(8'h32); apply_stimulus(8'h21);
    apply_stimulus(8'h23); apply_stimulus(8'h24);
    check_output("t5_full_count", {29'd0, a_count}, 32'd4);
    check_output("t5_ovf_set", {31'd0, a_ovf}, 32'd1);
    pop_expect("t5_pop_a", 8'h61);
    pop_expect("t5_pop_b", 8'h62);
    pop_expect("t5_pop_c", 8'h63);
    pop_expect("t5_pop_d", 8'h64);
    check_output("t5_drained", {29'd0, a_count}, 32'd0);
    check_output("t5_ovf_sticky", {31'd0, a_ovf}, 32'd1);
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    check_output("t5_ovf_clr", {31'd0, a_ovf}, 32'd0);

    // full: simultaneous push and pop keeps count, no overflow
    apply_stimulus(8'h1C); apply_stimulus(8'h32); apply_stimulus(8'h21); apply_stimulus(8'h23);
    @(negedge clk);
    scan_code = 8'h24; scan_valid = 1'b1; ascii_ready = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; ascii_ready = 1'b0;
    check_output("t5_pushpop_count", {29'd0, a_count}, 32'd4);
    check_output("t5_pushpop_ovf", {31'd0, a_ovf}, 32'd0);
    // full: overflow set beats clear in the same cycle
    @(negedge clk);
    scan_code = 8'h2B; scan_valid = 1'b1; clr_overflow = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; clr_overflow = 1'b0;
    check_output("t5_set_over_clr", {31'd0, a_ovf}, 32'd1);
    pop_expect("t5_wrap_b", 8'h62);
    pop_expect("t5_wrap_c", 8'h63);
    pop_expect("t5_wrap_d", 8'h64);
    pop_expect("t5_wrap_e", 8'h65);
    // empty: ready with a push only performs the push
    @(negedge clk);
    scan_code = 8'h34; scan_valid = 1'b1; ascii_ready = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; ascii_ready = 1'b0;
    check_output("t5_empty_pushpop", {29'd0, a_count}, 32'd1);
    pop_expect("t5_g", 8'h67);

    // DROP_UNKNOWN instance after a fresh reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_output("t6_b_rst_count", {28'd0, b_count}, 32'd0);
    apply_stimulus(8'h05);
    check_output("t6_b_drop", {28'd0, b_count}, 32'd0);
    check_output("t6_a_unknown", {29'd0, a_count}, 32'd1);
    apply_stimulus(8'h58);
    check_output("t6_b_caps", {31'd0, b_caps}, 32'd1);
    apply_stimulus(8'hF0);
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_async_b_caps", {31'd0, b_caps}, 32'd0);
    check_output("t6_async_b_valid", {31'd0, b_valid}, 32'd0);
    check_output("t6_async_a_count", {29'd0, a_count}, 32'd0);
    check_output("t6_async_a_data", {24'd0, a_data}, 32'h00);
    @(negedge clk); rst_n = 1'b1;
    apply_stimulus(8'h1C);
    check_output("t6_b_count", {28'd0, b_count}, 32'd1);
    check_output("t6_b_data", {24'd0, b_data}, 32'h61);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
